// File: rtl/sdram_wr_burst_buf_pkg.sv
// Shared types and helpers for the SDRAM write-burst buffer: FSM encoding,
// default geometry and width helpers.
package sdram_wr_burst_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BURST = 2'd2,
    ST_NEXT  = 2'd3
  } wb_state_t;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_DEPTH       = 512;
  localparam int DEF_BURST_LEN   = 256;
  localparam int DEF_BASE_ADDR   = 0;
  localparam int DEF_FRAME_WORDS = 307200;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sdram_wr_burst_buf_sync_fifo.sv
// Single-clock FIFO with level counter, registered read port and
// overflow/underflow strobes for the write-burst buffer.
module sdram_sync_fifo
  import sdram_wr_burst_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_pop,
  output logic                     o_ovf,
  output logic                     o_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_dout;
  logic              w_push;
  logic              w_pop;
  logic [LW-1:0]     w_level_nxt;

  assign w_push    = i_wr_en & ~r_full;
  assign w_pop     = i_rd_en & ~r_empty;
  assign o_ovf     = i_wr_en & r_full;
  assign o_udf     = i_rd_en & r_empty;
  assign o_pop     = w_pop;
  assign o_rd_data = r_dout;
  assign o_level   = r_level;
  assign o_full    = r_full;

  // Simultaneous push and pop leaves the level untouched.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == LW'(0));
    end
  end

endmodule

// File: rtl/sdram_wr_burst_buf.sv
// Write-side front end for the SDRAM controller: buffers pixels, requests a
// burst once BURST_LEN words are held, and walks a wrapping frame address.
module sdram_wr_burst_buf
  import sdram_wr_burst_buf_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int BURST_LEN   = DEF_BURST_LEN,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic                   S_CLK,
  input  logic                   RST_N,
  input  logic                   pix_valid,
  input  logic [DATA_W-1:0]      pix_data,
  output logic                   pix_ready,
  input  logic                   frame_start,
  output logic                   write_req,
  input  logic                   write_ack,
  output logic [ADDR_W-1:0]      sdram_addr,
  input  logic                   fifo_rd_req,
  output logic [DATA_W-1:0]      sdram_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int              LW    = level_width(DEPTH);
  localparam int              BW    = $clog2(BURST_LEN);
  localparam logic [ADDR_W:0] STEP  = (ADDR_W+1)'(BURST_LEN);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(BASE_ADDR + FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  wb_state_t         r_state;
  logic              r_write_req;
  logic [ADDR_W-1:0] r_addr;
  logic [BW-1:0]     r_beat;
  logic              r_pending;
  logic              r_ovf;
  logic              r_udf;
  logic              w_full;
  logic              w_pop;
  logic              w_ovf;
  logic              w_udf;
  logic [LW-1:0]     w_level;
  logic [ADDR_W:0]   w_addr_sum;

  sdram_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk     (S_CLK),
    .i_rst_n   (RST_N),
    .i_wr_en   (pix_valid),
    .i_wr_data (pix_data),
    .i_rd_en   (fifo_rd_req),
    .o_rd_data (sdram_data),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_pop     (w_pop),
    .o_ovf     (w_ovf),
    .o_udf     (w_udf)
  );

  // One extra bit so the end-of-frame compare cannot be fooled by carry-out.
  assign w_addr_sum = {1'b0, r_addr} + STEP;

  assign pix_ready  = ~w_full;
  assign fifo_level = w_level;
  assign write_req  = r_write_req;
  assign sdram_addr = r_addr;
  assign overflow   = r_ovf;
  assign underflow  = r_udf;

  // Burst sequencer, address generator and sticky error flags.
  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_write_req <= 1'b0;
      r_addr      <= BASE;
      r_beat      <= '0;
      r_pending   <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      if (w_ovf) r_ovf <= 1'b1;
      if (w_udf) r_udf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (frame_start) begin
            r_addr <= BASE;
          end
          if (w_level >= LW'(BURST_LEN)) begin
            r_state     <= ST_REQ;
            r_write_req <= 1'b1;
          end
        end
        ST_REQ: begin
          if (frame_start) r_pending <= 1'b1;
          if (write_ack) begin
            r_state     <= ST_BURST;
            r_write_req <= 1'b0;
            r_beat      <= '0;
          end
        end
        ST_BURST: begin
          if (frame_start) r_pending <= 1'b1;
          if (w_pop) begin
            if (r_beat == BW'(BURST_LEN - 1)) begin
              r_beat  <= '0;
              r_state <= ST_NEXT;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        ST_NEXT: begin
          // A restart seen here is applied directly rather than deferred again.
          if (r_pending || frame_start || (w_addr_sum >= LIMIT)) begin
            r_addr <= BASE;
          end else begin
            r_addr <= w_addr_sum[ADDR_W-1:0];
          end
          r_pending <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_write_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wr_burst_buf.sv
// Randomized bench for sdram_wr_burst_buf: acts as the SDRAM controller and
// checks every cycle against a queue-based model of buffer and address rules.
module tb_sdram_wr_burst_buf;

  localparam int DW    = 16;
  localparam int AW    = 20;
  localparam int DEPTH = 16;
  localparam int BL    = 8;
  localparam int BASE  = 32;
  localparam int FRAME = 48;

  logic          S_CLK = 1'b0;
  logic          RST_N;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          frame_start;
  logic          write_req;
  logic          write_ack;
  logic [AW-1:0] sdram_addr;
  logic          fifo_rd_req;
  logic [DW-1:0] sdram_data;
  logic [4:0]    fifo_level;
  logic          overflow;
  logic          underflow;

  always #25 S_CLK = ~S_CLK;

  sdram_wr_burst_buf #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BURST_LEN(BL),
    .BASE_ADDR(BASE), .FRAME_WORDS(FRAME)
  ) dut (
    .S_CLK(S_CLK), .RST_N(RST_N), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .frame_start(frame_start), .write_req(write_req),
    .write_ack(write_ack), .sdram_addr(sdram_addr), .fifo_rd_req(fifo_rd_req),
    .sdram_data(sdram_data), .fifo_level(fifo_level), .overflow(overflow),
    .underflow(underflow)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_dout;
  bit            m_ovf, m_udf, m_pend;
  int            m_addr;
  int            phase;      // 0 waiting for request, 1 request seen, 2 burst
  int            delay, pops_left, wait_cnt;
  bit            push_en, drain;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pix_ready"}, pix_ready, 1);
    check_val({tag, "_write_req"}, write_req, 0);
    check_val({tag, "_level"}, fifo_level, 0);
    check_val({tag, "_addr"}, sdram_addr, BASE);
    check_val({tag, "_ovf"}, overflow, 0);
    check_val({tag, "_udf"}, underflow, 0);
    check_val({tag, "_data"}, sdram_data, 0);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0; m_ovf = 0; m_udf = 0; m_pend = 0;
    m_addr = BASE; phase = 0; wait_cnt = 0; pops_left = 0; delay = 0;
  endtask

  task automatic cycle();
    bit v, rd, ack, fs, busy, push_ok, pop_ok;
    logic [DW-1:0] d;
    int lvl;
    @(negedge S_CLK);
    lvl = m_q.size();
    check_val("level", fifo_level, lvl);
    check_val("pix_ready", pix_ready, lvl != DEPTH);
    check_val("sdram_data", sdram_data, m_dout);
    check_val("overflow", overflow, m_ovf);
    check_val("underflow", underflow, m_udf);

    v    = push_en && ($urandom_range(3) != 0);
    d    = DW'($urandom);
    rd   = 0;
    ack  = 0;
    busy = write_req || (phase == 2);
    fs   = push_en && ($urandom_range(59) == 0);

    case (phase)
      0: begin
        if (write_req) begin
          check_val("req_addr", sdram_addr, m_addr);
          check_val("req_level", fifo_level >= BL, 1);
          phase    = 1;
          delay    = ($urandom_range(4) == 0) ? int'($urandom_range(40, 20)) : int'($urandom_range(3));
          wait_cnt = 0;
        end else if (lvl >= BL) begin
          wait_cnt++;
          if (wait_cnt > 8) begin
            check_val("req_timeout", write_req, 1);
            wait_cnt = 0;
          end
        end else begin
          wait_cnt = 0;
          rd = drain;
        end
      end
      1: begin
        check_val("req_hold", write_req, 1);
        if (delay == 0) begin
          ack = 1; phase = 2; pops_left = BL;
        end else begin
          delay--;
        end
      end
      default: begin
        check_val("req_drop", write_req, 0);
        rd = ($urandom_range(3) != 0);
      end
    endcase

    pix_valid = v; pix_data = d; fifo_rd_req = rd; write_ack = ack; frame_start = fs;

    if (fs) begin
      if (busy) m_pend = 1;
      else      m_addr = BASE;
    end
    push_ok = v && (lvl != DEPTH);
    pop_ok  = rd && (lvl != 0);
    if (v && lvl == DEPTH) m_ovf = 1;
    if (rd && lvl == 0)    m_udf = 1;
    if (pop_ok)  m_dout = m_q.pop_front();
    if (push_ok) m_q.push_back(d);
    if (phase == 2 && pop_ok) begin
      pops_left--;
      if (pops_left == 0) begin
        phase = 0;
        if (m_pend || (m_addr + BL >= BASE + FRAME)) m_addr = BASE;
        else                                         m_addr = m_addr + BL;
        m_pend = 0;
      end
    end
  endtask

  initial begin
    RST_N = 1'b0; pix_valid = 1'b1; pix_data = '0; frame_start = 1'b0;
    write_ack = 1'b0; fifo_rd_req = 1'b0; push_en = 0; drain = 0;
    model_reset();
    #100;
    #1;
    check_reset_outputs("reset");
    @(negedge S_CLK);
    RST_N = 1'b1; pix_valid = 1'b0;

    push_en = 1;
    repeat (3000) cycle();

    push_en = 0;
    for (int i = 0; i < 200 && !(phase == 0 && m_q.size() < BL); i++) cycle();
    check_val("settle", (phase == 0) && (m_q.size() < BL), 1);

    drain = 1;
    repeat (BL + 4) cycle();
    drain = 0;
    check_val("underflow_seen", underflow, 1);

    push_en = 1;
    for (int i = 0; i < 300 && !(phase == 2 && pops_left < BL); i++) cycle();
    check_val("burst_reached", phase == 2, 1);
    #5;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
